// File: rtl/vga_frame_scanner.sv
// Counter-based VGA raster engine: programmable H/V timing, scaled frame-buffer readout
// with read-latency alignment, colour-bar test pattern and 12-bit RGB output.
module vga_frame_scanner #(
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter int          IMG_W       = 256,
  parameter int          IMG_H       = 256,
  parameter int          SCALE_SHIFT = 1,
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 8,
  parameter int          MEM_LAT     = 1,
  parameter int          PIX_MODE    = 1,
  parameter logic [11:0] BORDER      = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pattern_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [11:0]       rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0]    H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]    V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]    ROW_MASK = V_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  // Per-pixel control word carried alongside the memory read latency
  localparam int PW    = 9;
  localparam int P_FS  = 8;
  localparam int P_ACT = 7;
  localparam int P_HS  = 6;
  localparam int P_VS  = 5;
  localparam int P_IMG = 4;
  localparam int P_PAT = 3;

  genvar gi;

  function automatic logic in_image(input logic [H_W-1:0] h, input logic [V_W-1:0] v);
    return (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE) &&
           (int'(h >> SCALE_SHIFT) < IMG_W) && (int'(v >> SCALE_SHIFT) < IMG_H);
  endfunction

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  logic [H_W-1:0]    r_h;
  logic [V_W-1:0]    r_v;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [H_W-1:0]    w_h_next;
  logic [V_W-1:0]    w_v_next;
  logic [ADDR_W-1:0] w_line_base_next;
  logic              w_h_wrap;
  logic              w_v_wrap;
  logic              w_row_end;

  always_comb begin
    w_h_wrap         = (r_h == H_LAST);
    w_v_wrap         = (r_v == V_LAST);
    w_row_end        = ((r_v & ROW_MASK) == ROW_MASK);
    w_h_next         = w_h_wrap ? '0 : r_h + H_W'(1);
    w_v_next         = r_v;
    w_line_base_next = r_line_base;
    if (w_h_wrap) begin
      if (w_v_wrap) begin
        w_v_next         = '0;
        w_line_base_next = '0;
      end else begin
        w_v_next = r_v + V_W'(1);
        if (w_row_end) begin
          w_line_base_next = r_line_base + ROW_STEP;
        end
      end
    end
  end

  // The address is computed from the next raster position so that mem_addr
  // lines up with the counters and the data returns MEM_LAT cycles later.
  logic [H_W-1:0]    w_nsx;
  logic              w_nin_img;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_nsx       = w_h_next >> SCALE_SHIFT;
  assign w_nin_img   = in_image(w_h_next, w_v_next);
  assign w_addr_next = w_line_base_next + ADDR_W'(w_nsx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h         <= '0;
      r_v         <= '0;
      r_line_base <= '0;
      r_mem_addr  <= '0;
    end else begin
      r_h         <= w_h_next;
      r_v         <= w_v_next;
      r_line_base <= w_line_base_next;
      if (w_nin_img) begin
        r_mem_addr <= w_addr_next;
      end
    end
  end

  assign mem_addr = r_mem_addr;

  logic [H_W-1:0] w_sx;
  logic           w_act;
  logic           w_hs;
  logic           w_vs;
  logic           w_in_img;
  logic           w_fs;

  assign w_sx     = r_h >> SCALE_SHIFT;
  assign w_act    = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
  assign w_hs     = (int'(r_h) >= H_ACTIVE + H_FP) && (int'(r_h) < H_ACTIVE + H_FP + H_SYNC);
  assign w_vs     = (int'(r_v) >= V_ACTIVE + V_FP) && (int'(r_v) < V_ACTIVE + V_FP + V_SYNC);
  assign w_in_img = in_image(r_h, r_v);
  assign w_fs     = (r_h == '0) && (r_v == '0);

  // Bar k starts at the first sx with sx*8 >= k*IMG_W, so the thresholds form a thermometer code
  logic [7:1] w_bar_ge;
  logic [2:0] w_bar;

  for (gi = 1; gi < 8; gi++) begin : g_bar
    localparam int BAR_T = (gi * IMG_W + 7) / 8;
    assign w_bar_ge[gi] = (int'(w_sx) >= BAR_T);
  end

  always_comb begin
    w_bar = '0;
    for (int i = 1; i < 8; i++) begin
      if (w_bar_ge[i]) begin
        w_bar = 3'(i);
      end
    end
    if (int'(w_sx) >= IMG_W) begin
      w_bar = '0;
    end
  end

  logic [PW-1:0] w_stage [MEM_LAT+1];
  logic [PW-1:0] w_tap;

  assign w_stage[0] = {w_fs, w_act, w_hs, w_vs, w_in_img, pattern_en, w_bar};

  for (gi = 0; gi < MEM_LAT; gi++) begin : g_dly
    logic [PW-1:0] r_dly;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dly <= '0;
      end else begin
        r_dly <= w_stage[gi];
      end
    end
    assign w_stage[gi+1] = r_dly;
  end

  assign w_tap = w_stage[MEM_LAT];

  logic [11:0] w_pix;

  if (PIX_MODE == 0) begin : g_rgb444
    assign w_pix = mem_data[11:0];
  end else begin : g_rgb332
    assign w_pix = {mem_data[7:5], mem_data[7], mem_data[4:2], mem_data[4],
                    mem_data[1:0], mem_data[1:0]};
  end

  logic [11:0] w_rgb_sel;

  always_comb begin
    w_rgb_sel = '0;
    if (!w_tap[P_ACT]) begin
      w_rgb_sel = '0;
    end else if (w_tap[P_PAT]) begin
      w_rgb_sel = bar_colour(w_tap[2:0]);
    end else if (!w_tap[P_IMG]) begin
      w_rgb_sel = BORDER;
    end else begin
      w_rgb_sel = w_pix;
    end
  end

  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [11:0] r_rgb;
  logic        r_frame_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_tap[P_HS] ? HS_POL : ~HS_POL;
      r_vsync       <= w_tap[P_VS] ? VS_POL : ~VS_POL;
      r_de          <= w_tap[P_ACT];
      r_rgb         <= w_rgb_sel;
      r_frame_start <= w_tap[P_FS];
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Randomised pattern_en / reset stimulus on a default-timing scanner and a small clipped one,
// checked every cycle against a raster model computed from pixel index arithmetic.
`timescale 1ns/1ps
module tb_vga_frame_scanner;

  typedef struct {
    int ha, hf, hsy, hb;
    int va, vf, vsy, vb;
    int hpol, vpol;
    int iw, ih, sh, lat, pm, border;
  } cfg_t;

  typedef struct {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] rgb;
  } exp_t;

  logic clk;
  logic rst;
  logic pattern_en;

  logic [15:0] d_addr;
  logic [7:0]  d_md = '0;
  logic        d_hs, d_vs, d_de, d_fs;
  logic [11:0] d_rgb;

  logic [7:0]  s_addr;
  logic [11:0] s_md1 = '0;
  logic [11:0] s_md2 = '0;
  logic        s_hs, s_vs, s_de, s_fs;
  logic [11:0] s_rgb;

  cfg_t cfg_d;
  cfg_t cfg_s;
  int   n_total = 0;
  int   n_bad   = 0;
  int   k       = 0;
  int   exp_addr_d = 0;
  int   exp_addr_s = 0;
  bit   pat_hist [8];

  vga_frame_scanner u_dfl (
    .clk         (clk),
    .rst         (rst),
    .pattern_en  (pattern_en),
    .mem_addr    (d_addr),
    .mem_data    (d_md),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .de          (d_de),
    .rgb         (d_rgb),
    .frame_start (d_fs)
  );

  vga_frame_scanner #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0),
    .IMG_W(12), .IMG_H(3), .SCALE_SHIFT(1),
    .ADDR_W(8), .DATA_W(12), .MEM_LAT(2), .PIX_MODE(0),
    .BORDER(12'h00F)
  ) u_sml (
    .clk         (clk),
    .rst         (rst),
    .pattern_en  (pattern_en),
    .mem_addr    (s_addr),
    .mem_data    (s_md2),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .de          (s_de),
    .rgb         (s_rgb),
    .frame_start (s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int memf(int a);
    return ((a * 73 + 29) ^ (a >> 2) ^ (a << 5)) & 'hFFF;
  endfunction

  // Frame memories: one and two cycles of read latency
  always @(posedge clk) d_md <= 8'(memf(int'(d_addr)));
  always @(posedge clk) begin
    s_md1 <= 12'(memf(int'(s_addr)));
    s_md2 <= s_md1;
  end

  function automatic logic [11:0] bar_rgb(int i);
    case (i)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // Frame-buffer address of raster pixel p, or -1 outside the scaled image
  function automatic int img_addr(cfg_t c, int p);
    int ht, vt, h, v, sx, sy;
    ht = c.ha + c.hf + c.hsy + c.hb;
    vt = c.va + c.vf + c.vsy + c.vb;
    h  = p % ht;
    v  = (p / ht) % vt;
    sx = h >> c.sh;
    sy = v >> c.sh;
    if (h < c.ha && v < c.va && sx < c.iw && sy < c.ih) return sy * c.iw + sx;
    return -1;
  endfunction

  // Expected outputs k clocks after reset release
  function automatic exp_t model(cfg_t c, int k_in, bit pat);
    exp_t e;
    int   ht, vt, p, h, v, sx, bar, d, a, r, g, b;
    bit   act;
    e.hs  = (c.hpol == 0);
    e.vs  = (c.vpol == 0);
    e.de  = 1'b0;
    e.fs  = 1'b0;
    e.rgb = '0;
    if (k_in < c.lat + 1) return e;
    p   = k_in - c.lat - 1;
    ht  = c.ha + c.hf + c.hsy + c.hb;
    vt  = c.va + c.vf + c.vsy + c.vb;
    h   = p % ht;
    v   = (p / ht) % vt;
    act = (h < c.ha) && (v < c.va);
    e.de = act;
    e.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsy) ? (c.hpol != 0) : (c.hpol == 0);
    e.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsy) ? (c.vpol != 0) : (c.vpol == 0);
    e.fs = (h == 0) && (v == 0);
    sx  = h >> c.sh;
    a   = img_addr(c, p);
    if (!act) begin
      e.rgb = '0;
    end else if (pat) begin
      bar = (sx >= c.iw) ? 0 : (sx * 8) / c.iw;
      if (bar > 7) bar = 7;
      e.rgb = bar_rgb(bar);
    end else if (a < 0) begin
      e.rgb = 12'(c.border);
    end else begin
      d = memf(a);
      if (c.pm == 1) begin
        d = d & 255;
        r = ((d >> 5) & 7) * 2 + ((d >> 7) & 1);
        g = ((d >> 2) & 7) * 2 + ((d >> 4) & 1);
        b = (d & 3) * 4 + (d & 3);
        e.rgb = 12'(r * 256 + g * 16 + b);
      end else begin
        e.rgb = 12'(d);
      end
    end
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_outputs(input string who, input cfg_t c, input int kk, input bit pat,
                               input logic hs, input logic vs, input logic de_o,
                               input logic fs, input logic [11:0] rgb_o);
    exp_t e;
    e = model(c, kk, pat);
    check_val($sformatf("%s.hsync@%0d", who, kk), 32'(hs), 32'(e.hs));
    check_val($sformatf("%s.vsync@%0d", who, kk), 32'(vs), 32'(e.vs));
    check_val($sformatf("%s.de@%0d", who, kk), 32'(de_o), 32'(e.de));
    check_val($sformatf("%s.frame_start@%0d", who, kk), 32'(fs), 32'(e.fs));
    check_val($sformatf("%s.rgb@%0d", who, kk), 32'(rgb_o), 32'(e.rgb));
  endtask

  task automatic check_all();
    int a;
    bit pd, ps;
    a = img_addr(cfg_d, k);
    if (a >= 0) exp_addr_d = a;
    a = img_addr(cfg_s, k);
    if (a >= 0) exp_addr_s = a;
    pd = (k >= cfg_d.lat + 1) ? pat_hist[(k - cfg_d.lat - 1) % 8] : 1'b0;
    ps = (k >= cfg_s.lat + 1) ? pat_hist[(k - cfg_s.lat - 1) % 8] : 1'b0;
    check_val($sformatf("dfl.mem_addr@%0d", k), 32'(d_addr), 32'(exp_addr_d & 'hFFFF));
    check_val($sformatf("sml.mem_addr@%0d", k), 32'(s_addr), 32'(exp_addr_s & 'hFF));
    check_outputs("dfl", cfg_d, k, pd, d_hs, d_vs, d_de, d_fs, d_rgb);
    check_outputs("sml", cfg_s, k, ps, s_hs, s_vs, s_de, s_fs, s_rgb);
  endtask

  // Outputs while reset is held: model at k=0 gives the reset values
  task automatic check_reset(input string when);
    check_val({"dfl.mem_addr ", when}, 32'(d_addr), 32'd0);
    check_val({"sml.mem_addr ", when}, 32'(s_addr), 32'd0);
    check_outputs({"dfl ", when}, cfg_d, 0, 1'b0, d_hs, d_vs, d_de, d_fs, d_rgb);
    check_outputs({"sml ", when}, cfg_s, 0, 1'b0, s_hs, s_vs, s_de, s_fs, s_rgb);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst        = 1'b0;
    k          = 0;
    exp_addr_d = 0;
    exp_addr_s = 0;
    pat_hist[0] = pattern_en;
    #1;
    check_all();
  endtask

  task automatic run_cycles(input int seg, input int n, input int odds);
    int toggles = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      #1;
      if ($urandom_range(0, odds - 1) == 0) begin
        pattern_en = ~pattern_en;
        toggles++;
      end
      pat_hist[k % 8] = pattern_en;
      @(negedge clk);
      check_all();
    end
    $display("segment %0d: %0d cycles, %0d pattern toggles, checks so far %0d", seg, n, toggles, n_total);
  endtask

  initial begin
    cfg_d = '{ha: 640, hf: 16, hsy: 96, hb: 48, va: 480, vf: 10, vsy: 2, vb: 33,
              hpol: 0, vpol: 0, iw: 256, ih: 256, sh: 1, lat: 1, pm: 1, border: 'h000};
    cfg_s = '{ha: 20, hf: 3, hsy: 4, hb: 5, va: 12, vf: 2, vsy: 2, vb: 3,
              hpol: 1, vpol: 0, iw: 12, ih: 3, sh: 1, lat: 2, pm: 0, border: 'h00F};
    rst        = 1'b0;
    pattern_en = 1'b0;
    #2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("initial reset");
    release_reset();
    run_cycles(1, 2500, 24);

    // Asynchronous reset between clock edges, mid-line in both rasters
    repeat ($urandom_range(5, 40)) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset("async assert");
    repeat (2) begin
      @(negedge clk);
      check_reset("held");
    end
    pattern_en = 1'($urandom_range(0, 1));
    release_reset();
    run_cycles(2, 1800, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
